// File: rtl/iot_pkg.sv
// Shared definitions for the IoT data-filter front end.
package iot_pkg;

  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned WORD_W              = 128;
  localparam int unsigned WORD_BYTES_DEF      = WORD_W / BYTE_W;
  localparam int unsigned WORDS_PER_ROUND_DEF = 8;
  localparam int unsigned NUM_ROUNDS_DEF      = 64;
  localparam int unsigned CNT_W               = 6;
  localparam int unsigned CYC_W               = 8;
  localparam int unsigned FN_W                = 3;
  localparam int unsigned ST_W                = 3;

  // Control-bus state codes seen by the filter stages.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_OUT  = 3'b010,
    ST_DONE = 3'b011
  } iot_state_e;

  // Function select: zero disables the whole datapath.
  localparam logic [FN_W-1:0] FN_OFF = 3'b000;

  // True when a function select code enables the datapath.
  function automatic logic fn_enabled(input logic [FN_W-1:0] f);
    return f != FN_OFF;
  endfunction

endpackage

// File: rtl/iot_byte_packer.sv
// Byte-to-word shift register with a byte index and a word-complete flag.
module iot_byte_packer
  import iot_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [BYTE_W-1:0]            byte_i,
  output logic [BYTE_W*WORD_BYTES-1:0] data_o,
  output logic [CNT_W-1:0]             cnt_o,
  output logic                         word_done_o
);

  localparam int unsigned      DATA_W   = BYTE_W * WORD_BYTES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              done_q, done_d;

  // Next-state: clear wins over push; the first byte after a clear lands at index 0.
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    done_d  = done_q;
    if (clr_i) begin
      data_d  = '0;
      cnt_d   = '0;
      first_d = 1'b1;
      done_d  = 1'b0;
    end else if (push_i) begin
      data_d  = {data_q[DATA_W-BYTE_W-1:0], byte_i};
      cnt_d   = (first_q || (cnt_q == CNT_LAST)) ? '0 : cnt_q + CNT_W'(1);
      first_d = 1'b0;
      done_d  = (cnt_d == CNT_LAST);
    end
  end

  // Packer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  assign data_o      = data_q;
  assign cnt_o       = cnt_q;
  assign word_done_o = done_q;

endmodule

// File: rtl/iot_word_collector.sv
// Front end of the IoT filter datapath: packs bytes into words, groups words
// into rounds and drives the shared control bus for the filter stages.
module iot_word_collector
  import iot_pkg::*;
#(
  parameter int unsigned WORD_BYTES      = WORD_BYTES_DEF,
  parameter int unsigned WORDS_PER_ROUND = WORDS_PER_ROUND_DEF,
  parameter int unsigned NUM_ROUNDS      = NUM_ROUNDS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FN_W-1:0]              fn_sel,
  input  logic                         in_en,
  input  logic [BYTE_W-1:0]            iot_in,
  output logic                         busy,
  output logic [BYTE_W*WORD_BYTES-1:0] data,
  output logic [CNT_W-1:0]             cnt,
  output logic [CYC_W-1:0]             cycle_cnt,
  output logic [ST_W-1:0]              state,
  output logic                         valid,
  output logic                         done
);

  localparam int unsigned      RND_W       = $clog2(NUM_ROUNDS + 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(WORD_BYTES - 2);
  localparam logic [CYC_W-1:0] CYC_LAST    = CYC_W'(WORDS_PER_ROUND - 1);
  localparam logic [RND_W-1:0] RND_LIMIT   = RND_W'(NUM_ROUNDS);

  iot_state_e              state_q, state_d;
  logic [FN_W-1:0]         fn_sel_q;
  logic [CYC_W-1:0]        cycle_cnt_q, cycle_cnt_d;
  logic [RND_W-1:0]        round_cnt_q, round_cnt_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  logic                    clr_c;
  logic                    accept_c;
  logic [BYTE_W*WORD_BYTES-1:0] pk_data;
  logic [CNT_W-1:0]        pk_cnt;
  logic                    pk_word_done;

  // Abort on a select change mid-run (also exits DONE), or on disable outside IDLE.
  always_comb begin
    clr_c = 1'b0;
    if ((state_q != ST_IDLE) && (fn_sel != fn_sel_q)) clr_c = 1'b1;
    if ((state_q != ST_IDLE) && !fn_enabled(fn_sel)) clr_c = 1'b1;
  end

  // A byte is taken only while collecting, enabled, not busy and not aborting.
  always_comb begin
    accept_c = in_en && !busy_q && fn_enabled(fn_sel) && !clr_c &&
               ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  end

  iot_byte_packer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr_c),
    .push_i      (accept_c),
    .byte_i      (iot_in),
    .data_o      (pk_data),
    .cnt_o       (pk_cnt),
    .word_done_o (pk_word_done)
  );

  // Next state, word/round counters and registered bus flags.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    round_cnt_d = round_cnt_q;
    if (clr_c) begin
      state_d     = ST_IDLE;
      cycle_cnt_d = '0;
      round_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept_c) state_d = ST_LOAD;
        ST_LOAD: begin
          if (accept_c && (pk_cnt == CNT_PRELAST) && (cycle_cnt_q == CYC_LAST))
            state_d = ST_OUT;
        end
        ST_OUT: begin
          round_cnt_d = round_cnt_q + RND_W'(1);
          state_d     = (round_cnt_d < RND_LIMIT) ? ST_LOAD : ST_DONE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
      // First byte of a new word after a completed one advances the word index.
      if (accept_c && pk_word_done)
        cycle_cnt_d = (cycle_cnt_q == CYC_LAST) ? '0 : cycle_cnt_q + CYC_W'(1);
    end
    busy_d  = (state_d == ST_OUT) || (state_d == ST_DONE) || !fn_enabled(fn_sel);
    valid_d = (state_d == ST_OUT);
    done_d  = (state_d == ST_DONE);
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fn_sel_q    <= FN_OFF;
      cycle_cnt_q <= '0;
      round_cnt_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fn_sel_q    <= fn_sel;
      cycle_cnt_q <= cycle_cnt_d;
      round_cnt_q <= round_cnt_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign data      = pk_data;
  assign cnt       = pk_cnt;
  assign cycle_cnt = cycle_cnt_q;
  assign state     = state_q;
  assign valid     = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_iot_word_collector.sv
// Directed bench for iot_word_collector (two rounds per run).
module tb_iot_word_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   fn_sel = 3'd3;
  logic         in_en = 1'b0;
  logic [7:0]   iot_in = 8'h00;
  logic         busy;
  logic [127:0] data;
  logic [5:0]   cnt;
  logic [7:0]   cycle_cnt;
  logic [2:0]   state;
  logic         valid;
  logic         done;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_w;

  iot_word_collector #(
    .WORD_BYTES      (16),
    .WORDS_PER_ROUND (8),
    .NUM_ROUNDS      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fn_sel    (fn_sel),
    .in_en     (in_en),
    .iot_in    (iot_in),
    .busy      (busy),
    .data      (data),
    .cnt       (cnt),
    .cycle_cnt (cycle_cnt),
    .state     (state),
    .valid     (valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_en  = 1'b1;
    iot_in = b;
    step();
  endtask

  initial begin
    // Reset values
    #7;
    check("rst_state", 128'(state), 128'd0);
    check("rst_data", data, 128'd0);
    check("rst_cnt", 128'(cnt), 128'd0);
    check("rst_flags", 128'({busy, valid, done, cycle_cnt}), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 1: word 0 = bytes 00..0F
    for (int i = 0; i < 16; i++) send(8'(i));
    check("w0_cnt", 128'(cnt), 128'd15);
    check("w0_data", data, 128'h000102030405060708090a0b0c0d0e0f);
    check("w0_state", 128'(state), 128'd1);
    check("w0_cyc", 128'(cycle_cnt), 128'd0);

    // 2: words 1..7, word k = all bytes 0x10*k
    for (int k = 1; k < 7; k++)
      for (int j = 0; j < 16; j++) send(8'(16 * k));
    check("w6_cyc", 128'(cycle_cnt), 128'd6);
    for (int j = 0; j < 15; j++) send(8'h70);
    check("w7_pre_cnt", 128'(cnt), 128'd14);
    check("w7_pre_state", 128'(state), 128'd1);
    check("w7_pre_valid", 128'(valid), 128'd0);
    send(8'h70);
    check("out_state", 128'(state), 128'd2);
    check("out_valid", 128'(valid), 128'd1);
    check("out_busy", 128'(busy), 128'd1);
    check("out_cyc", 128'(cycle_cnt), 128'd7);
    check("out_cnt", 128'(cnt), 128'd15);
    check("out_data", data, {16{8'h70}});

    // 3: in_en held through OUT; that byte is dropped
    send(8'hAA);
    check("post_out_state", 128'(state), 128'd1);
    check("post_out_valid", 128'(valid), 128'd0);
    check("post_out_data", data, {16{8'h70}});
    check("post_out_busy", 128'(busy), 128'd0);
    send(8'hBB);
    exp_w = {{15{8'h70}}, 8'hBB};
    check("r2_cnt", 128'(cnt), 128'd0);
    check("r2_cyc", 128'(cycle_cnt), 128'd0);
    check("r2_data", data, exp_w);

    // 4: second round -> DONE
    for (int j = 0; j < 15; j++) send(8'h00);
    for (int k = 1; k < 8; k++)
      for (int j = 0; j < 16; j++) send(8'(16 * k));
    check("out2_valid", 128'(valid), 128'd1);
    check("out2_state", 128'(state), 128'd2);
    in_en = 1'b0;
    step();
    check("done_state", 128'(state), 128'd3);
    check("done_flag", 128'(done), 128'd1);
    check("done_busy", 128'(busy), 128'd1);
    check("done_valid", 128'(valid), 128'd0);
    send(8'h55);
    check("done_hold_data", data, {16{8'h70}});
    check("done_hold_cnt", 128'(cnt), 128'd15);
    check("done_hold_state", 128'(state), 128'd3);
    fn_sel = 3'd4;
    in_en  = 1'b0;
    step();
    check("exit_state", 128'(state), 128'd0);
    check("exit_done", 128'(done), 128'd0);
    check("exit_data", data, 128'd0);

    // 5: abort on fn_sel change after 5 bytes of word 2
    fn_sel = 3'd3;
    step();
    check("idle_fnchg_state", 128'(state), 128'd0);
    for (int i = 0; i < 37; i++) send(8'(i + 1));
    check("pre_abort_cnt", 128'(cnt), 128'd4);
    check("pre_abort_cyc", 128'(cycle_cnt), 128'd2);
    fn_sel = 3'd1;
    send(8'hEE);
    check("abort_state", 128'(state), 128'd0);
    check("abort_cnt", 128'(cnt), 128'd0);
    check("abort_cyc", 128'(cycle_cnt), 128'd0);
    check("abort_data", data, 128'd0);

    // 6: async reset at cnt=9 of word 4
    in_en = 1'b0;
    step();
    for (int i = 0; i < 74; i++) send(8'(i));
    check("pre_rst_cnt", 128'(cnt), 128'd9);
    check("pre_rst_cyc", 128'(cycle_cnt), 128'd4);
    in_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", data, 128'd0);
    check("async_rst_ctl", 128'({state, cnt, cycle_cnt, busy, valid, done}), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) send(8'(8'hA0 + i));
    check("fresh_data", data, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    check("fresh_cnt", 128'(cnt), 128'd15);
    check("fresh_cyc", 128'(cycle_cnt), 128'd0);

    // fn_sel = 0: forced IDLE, busy, bytes ignored
    fn_sel = 3'd0;
    in_en  = 1'b0;
    step();
    check("off_state", 128'(state), 128'd0);
    check("off_busy", 128'(busy), 128'd1);
    send(8'h77);
    check("off_cnt", 128'(cnt), 128'd0);
    check("off_data", data, 128'd0);
    in_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
